// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze, debug halt.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TMO = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        branch_reset,
    output logic        pipe_freeze,
    output logic        halted,
    output logic        mem_timeout,
    output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TMO);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic       r_mem_timeout;
    logic       w_set_timeout;
    logic       w_load_use;
    logic       w_mem_miss;

    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign w_mem_miss = mem_req && !mem_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_timer       <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_mem_timeout <= r_mem_timeout | w_set_timeout;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_set_timeout = 1'b0;
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        idex_bubble   = 1'b0;
        branch_reset  = 1'b0;
        pipe_freeze   = 1'b0;
        halted        = 1'b0;

        case (r_state)
            ST_RUN: begin
                // Priority: memory miss, taken branch, load-use, halt request.
                if (w_mem_miss) begin
                    pipe_freeze = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    w_timer_nxt = 8'd1;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    branch_reset = 1'b1;
                end else if (w_load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                pipe_freeze = 1'b1;
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                if (mem_ready) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RUN;
                end else if (r_timer == TMO_LIMIT) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = ST_HALT;
                end else if (r_timer != 8'hFF) begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            ST_HALT: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
                halted      = 1'b1;
                if (resume) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_RUN;
            end
        endcase

        // Control outputs are forced low while reset is asserted.
        if (!reset) begin
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            idex_bubble  = 1'b0;
            branch_reset = 1'b0;
            pipe_freeze  = 1'b0;
            halted       = 1'b0;
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (branch_reset && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
